// File: rtl/trap_csr_unit.sv
// Trap CSR unit: owns STATUS/INTMASK/SCAUSE/SEPC and the taken-trap cause,
// and sequences trap entry (flush, vector redirect) and trap return.
module trap_csr_unit #(
  parameter logic [31:0] VECTOR_BASE     = 32'h0000_1000,
  parameter int          VEC_STRIDE_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_signal,
  input  logic        exl_set,
  input  logic [2:0]  int_pend,
  input  logic [7:0]  src_set,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        sret,
  input  logic        csr_we,
  input  logic [1:0]  csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [7:0]  status,
  output logic [7:0]  intmask,
  output logic [7:0]  scause,
  output logic [2:0]  trap_cause,
  output logic [31:0] sepc,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, ENTER, VECTOR, RET} state_t;

  state_t      state, state_next;
  logic [7:0]  status_next, intmask_next, scause_next, scause_clr;
  logic [2:0]  trap_cause_next;
  logic [31:0] sepc_next;
  logic [31:0] vector_pc;
  logic        trap_take;

  assign trap_take = int_signal & exl_set & ex_valid;
  assign vector_pc = VECTOR_BASE + (32'(trap_cause) << VEC_STRIDE_LOG2);

  always_comb begin
    state_next      = state;
    status_next     = status;
    intmask_next    = intmask;
    trap_cause_next = trap_cause;
    sepc_next       = sepc;
    scause_clr      = 8'h00;
    case (state)
      IDLE: begin
        // A trap wins over sret/CSR writes; the dropped instruction re-executes after return.
        if (trap_take) begin
          state_next              = ENTER;
          sepc_next               = ex_pc;
          status_next[0]          = 1'b1;
          trap_cause_next         = int_pend;
          scause_clr[int_pend]    = 1'b1;
        end else if (sret && ex_valid) begin
          state_next = RET;
        end else if (csr_we && ex_valid) begin
          case (csr_addr)
            2'd0: status_next  = csr_wdata[7:0];
            2'd1: intmask_next = csr_wdata[7:0];
            2'd2: scause_clr   = csr_wdata[7:0];
            2'd3: sepc_next    = {csr_wdata[31:2], 2'b00};
            default: ;
          endcase
        end
      end
      ENTER:  state_next = VECTOR;
      VECTOR: state_next = IDLE;
      RET: begin
        state_next     = IDLE;
        status_next[0] = 1'b0;
      end
      default: state_next = IDLE;
    endcase
    // New pulses are applied after clears so a same-cycle set survives.
    scause_next = (scause & ~scause_clr) | src_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      status     <= 8'h00;
      intmask    <= 8'h00;
      scause     <= 8'h00;
      trap_cause <= 3'd0;
      sepc       <= 32'h0;
    end else begin
      state      <= state_next;
      status     <= status_next;
      intmask    <= intmask_next;
      scause     <= scause_next;
      trap_cause <= trap_cause_next;
      sepc       <= sepc_next;
    end
  end

  assign flush    = (state != IDLE);
  assign redirect = (state == VECTOR) || (state == RET);

  always_comb begin
    redirect_pc = 32'h0;
    if (state == VECTOR)   redirect_pc = vector_pc;
    else if (state == RET) redirect_pc = sepc;
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      2'd0: csr_rdata = {24'h0, status};
      2'd1: csr_rdata = {24'h0, intmask};
      2'd2: csr_rdata = {24'h0, scause};
      2'd3: csr_rdata = sepc;
      default: ;
    endcase
  end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Sits directly downstream of ExceptionUnit.
- Owns the architectural trap registers: STATUS, INTMASK, SCAUSE pending, SEPC and the latched trap cause. Drives STATUS, INTMASK and SCAUSE back into ExceptionUnit.
- Consumes INT_Signal, EXL_Set and INT_PEND to perform trap entry: save PC, set EXL, flush, redirect to vector.
- Also performs trap return (sret) and services software CSR reads/writes from EX.

Parameters:
VECTOR_BASE, 32'h0000_1000, handler table base address
VEC_STRIDE_LOG2, 4, log2 byte spacing between handler entries (16 B)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
int_signal  in  1  ExceptionUnit INT_Signal
exl_set  in  1  ExceptionUnit EXL_Set
int_pend  in  3  ExceptionUnit INT_PEND (cause index)
src_set  in  8  one-cycle cause pulses (bit0 timer, bit1 illegal, bit2 ecall, 7:3 external)
ex_valid  in  1  EX stage holds a valid instruction
ex_pc  in  32  PC of instruction in EX
sret  in  1  EX executing trap return (qualified by ex_valid)
csr_we  in  1  CSR write from EX (qualified by ex_valid)
csr_addr  in  2  0 STATUS, 1 INTMASK, 2 SCAUSE, 3 SEPC
csr_wdata  in  32  write data
csr_rdata  out  32  read data, combinational from csr_addr
status  out  8  to ExceptionUnit STATUS ([1]=IE, [0]=EXL)
intmask  out  8  to ExceptionUnit INTMASK
scause  out  8  to ExceptionUnit EX_SCAUSE (sticky pending)
trap_cause  out  3  cause index of last taken trap
sepc  out  32  saved PC
flush  out  1  kill IF/ID/EX
redirect  out  1  PC override valid
redirect_pc  out  32  PC override value

Behaviour:
- Reset (async, rst_n low): all registers and outputs 0; state IDLE.
  - IE=0 out of reset, so no trap can be taken until software sets it.
- FSM states: IDLE, ENTER, VECTOR, RET.
- IDLE
  - int_signal&exl_set & ex_valid -> ENTER. That cycle's register update:
    - sepc<=ex_pc
    - status[0]<=1
    - trap_cause<=int_pend
    - scause[int_pend]<=0
  - int_signal while !ex_valid: wait in IDLE (pipeline bubble); scause stays pending.
  - sret&ex_valid (no trap) -> RET.
  - csr_we&ex_valid (no trap, no sret): write the selected register.
- ENTER: flush=1 for exactly one cycle -> VECTOR.
- VECTOR: redirect=1, redirect_pc=VECTOR_BASE+(trap_cause<<VEC_STRIDE_LOG2), flush=1 -> IDLE.
- RET: redirect=1, redirect_pc=sepc, flush=1, status[0]<=0 at cycle end -> IDLE.
- flush/redirect are registered state decodes; 0 in IDLE.
- Trap latency: int_signal sampled at edge N; flush high N+1..N+2; redirect high N+2.
- SCAUSE
  - bit i set on src_set[i] in any state.
  - Cleared by CSR write-1-to-clear (addr 2, wdata[7:0]), or by trap entry for bit int_pend.
  - Set and clear of the same bit in the same cycle: set wins.
- CSR writes
  - STATUS: wdata[7:0], all 8 bits writable.
  - INTMASK: wdata[7:0].
  - SEPC: wdata[31:2], bits[1:0] forced 0.
- csr_rdata: zero-extended 8-bit registers or sepc; always valid, any state.
- Priority in IDLE: trap > sret > csr_we. A trap drops the same-cycle sret/csr write (that instruction is flushed, re-executed after return).
- Outside IDLE: int_signal, sret and csr_we ignored; src_set still accumulates.
- Multiple pending bits: ExceptionUnit reports int_pend=7, so trap_cause=7 and only scause[7] is cleared. Other bits remain pending for the handler to clear by W1C.
- EXL nesting: int_signal cannot assert while status[0]=1, so no re-entry. A pending cause fires no earlier than the cycle after RET.
- Reset mid-ENTER/VECTOR/RET: immediately IDLE, flush/redirect deasserted.

Test Plan:
- Reset: rst_n low mid-VECTOR -> flush=0, redirect=0, status=0, sepc=0 asynchronously; rdata for every addr = 0.
- Timer trap:
  - Setup: write STATUS=8'h02, INTMASK=8'h01; pulse src_set=8'h01; drive int_signal=exl_set=1, int_pend=0 with ex_pc=32'h0000_0240.
  - Response: sepc=32'h240, status=8'h03, scause=0, flush for 2 cycles, redirect_pc=32'h0000_1000.
- Ecall cause: int_pend=2 -> redirect_pc=32'h0000_1020, trap_cause=2.
- Return: in handler, assert sret with ex_valid -> next cycle redirect=1, redirect_pc=sepc, then status=8'h02.
- Priority/collision:
  - Same cycle int_signal+csr_we(INTMASK=8'hFF) -> intmask unchanged.
  - Same cycle src_set[1]=1 and W1C of bit 1 -> scause[1]=1.
- Bubble / multi-pending:
  - int_signal with ex_valid=0 for 3 cycles -> no flush; trap taken when ex_valid rises.
  - scause=8'h05 with int_pend=7 -> trap_cause=7, scause stays 8'h05.
